// File: rtl/adder_share_sequencer_pkg.sv
// Shared encodings for the adder/display sharing block and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_share_sequencer_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // A hold time of zero still needs one HOLD cycle for the FSM to pass through.
    function automatic int hold_eff(input int h);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/adder_share_sequencer_if.sv
// Bundle of requester, adder and display signals around the sharing sequencer.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their ack pulse is seen.
// Ports: req/op1/op2 per requester, add_in1/add_in2/add_out to the adder,
//        disp_val/disp_en to the display decoder, ack_a/ack_b/owner/busy status.
interface adder_share_sequencer_if
    import adder_share_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             req_a;
    logic [WIDTH-1:0] op1_a;
    logic [WIDTH-1:0] op2_a;
    logic             req_b;
    logic [WIDTH-1:0] op1_b;
    logic [WIDTH-1:0] op2_b;
    logic [WIDTH-1:0] add_in1;
    logic [WIDTH-1:0] add_in2;
    logic [WIDTH-1:0] add_out;
    logic [WIDTH-1:0] disp_val;
    logic             disp_en;
    logic             ack_a;
    logic             ack_b;
    logic             owner;
    logic             busy;

    // Sequencer side.
    modport slave (
        input  req_a, op1_a, op2_a, req_b, op1_b, op2_b, add_out,
        output add_in1, add_in2, disp_val, disp_en, ack_a, ack_b, owner, busy
    );

    // Requester / adder / display side.
    modport master (
        output req_a, op1_a, op2_a, req_b, op1_b, op2_b, add_out,
        input  add_in1, add_in2, disp_val, disp_en, ack_a, ack_b, owner, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, grants the side that did not win last.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when to act on grant_valid.
// Ports: req_a, req_b, last_owner in; grant_valid, grant_id out (OWN_A/OWN_B).
module rr_arbiter2
    import adder_share_sequencer_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_id    = OWN_A;
        if (req_a && req_b) begin
            grant_id = ~last_owner;
        end else if (req_b) begin
            grant_id = OWN_B;
        end
    end

endmodule

// File: rtl/adder_share_sequencer.sv
// Shares one adder and display path between requesters A and B, round-robin.
// Latency: operands at adder 1 cycle after grant, sum displayed from cycle 2, ack at HOLD+2.
// Backpressure: losing/late requests wait in place; req must stay high until ack.
// Ports: clk, rst (sync, active-high); bus = slave modport of adder_share_sequencer_if.
module adder_share_sequencer
    import adder_share_sequencer_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_share_sequencer_if.slave bus
);

    localparam int HC = hold_eff(HOLD_CYCLES);
    localparam int CW = (HC > 1) ? $clog2(HC) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] sel_op1;
    logic [WIDTH-1:0] sel_op2;

    rr_arbiter2 u_arb (
        .req_a       (bus.req_a),
        .req_b       (bus.req_b),
        .last_owner  (bus.owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_op1 = (grant_id == OWN_B) ? bus.op1_b : bus.op1_a;
        sel_op2 = (grant_id == OWN_B) ? bus.op2_b : bus.op2_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.add_in1  <= '0;
            bus.add_in2  <= '0;
            bus.disp_val <= '0;
            bus.disp_en  <= 1'b0;
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.busy     <= 1'b0;
            // Owner starts as B so that A wins the first tie.
            bus.owner    <= OWN_B;
        end else begin
            // Acks are single-cycle pulses, only ever raised for the DONE cycle.
            bus.ack_a <= 1'b0;
            bus.ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        bus.owner   <= grant_id;
                        bus.add_in1 <= sel_op1;
                        bus.add_in2 <= sel_op2;
                        bus.busy    <= 1'b1;
                        state       <= ADD;
                    end
                end
                ADD: begin
                    // Adder has had a full cycle to settle on the latched operands.
                    bus.disp_val <= bus.add_out;
                    bus.disp_en  <= 1'b1;
                    cnt          <= CW'(HC - 1);
                    state        <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        if (bus.owner == OWN_B) begin
                            bus.ack_b <= 1'b1;
                        end else begin
                            bus.ack_a <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
